aes_inv_cipher_iter: RTL

//  Iterative AES-128 inverse cipher: decrypts one 128-bit block per 12 cycles, one round per clock.

---
 rtl/aes_pkg.sv | 128 ++++++++++++
 rtl/aes_key_expand_128.sv | 64 ++++++
 rtl/aes_inv_cipher_iter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// AES helper package: shared types, the inverse-cipher state encoding and
// byte/word transforms. Byte n of a block is at bits [8n+7:8n] and word n
// is at bits [32n+31:32n]. S-box values are derived arithmetically: a
// GF(2^8) inverse followed by the affine map.
package aes_pkg;

  localparam int AES128_NR = 10;

  typedef logic [127:0] aes_block_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    KEXP  = 3'd1,
    READY = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } aes_inv_state_e;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply using shift-and-add.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254. This maps 0 to 0, as the S-box requires.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] b;
    b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return ginv(b);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Byte 0 is the low byte, so [a0,a1,a2,a3] -> [a1,a2,a3,a0] is a right rotate.
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[7:0], w[31:8]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Row r of column c is byte 4c+r. Row r rotates right by r columns.
  function automatic aes_block_t inv_shift_rows(input aes_block_t s);
    aes_block_t o;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(4*((c+r)%4)+r) +: 8] = s[8*(4*c+r) +: 8];
      end
    end
    return o;
  endfunction

  function automatic aes_block_t inv_sub_bytes(input aes_block_t s);
    aes_block_t o;
    for (int n = 0; n < 16; n++) o[8*n +: 8] = inv_sbox(s[8*n +: 8]);
    return o;
  endfunction

  function automatic aes_block_t inv_mix_columns(input aes_block_t s);
    aes_block_t o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8];
      a1 = s[32*c+8 +: 8];
      a2 = s[32*c+16 +: 8];
      a3 = s[32*c+24 +: 8];
      o[32*c +: 8]    = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[32*c+8 +: 8]  = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[32*c+16 +: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[32*c+24 +: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  function automatic aes_block_t add_round_key(input aes_block_t s, input aes_block_t k);
    return s ^ k;
  endfunction

endpackage

// File: rtl/aes_key_expand_128.sv
// AES-128 forward key schedule. Produces one round key per step and keeps
// all 11 round keys in a register store, which is read through one indexed
// port.
module aes_key_expand_128
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       clear,
  input  logic       step,
  input  logic [3:0] idx,
  input  aes_block_t key,
  input  logic [3:0] rd_idx,
  output aes_block_t rd_key
);

  aes_block_t  rk_r [AES128_NR+1];
  aes_block_t  prev_s;
  aes_block_t  next_s;
  logic [31:0] t_s;
  logic [31:0] w0_s, w1_s, w2_s, w3_s;
  logic        idx_ok_s;

  // Derive round key idx from round key idx-1.
  always_comb begin
    idx_ok_s = (idx >= 4'd1) && (idx <= 4'd10);
    if (idx_ok_s) begin
      prev_s = rk_r[idx - 4'd1];
    end else begin
      prev_s = 128'h0;
    end
    t_s    = sub_word(rot_word(prev_s[127:96])) ^ {24'h0, rcon(idx)};
    w0_s   = prev_s[31:0]   ^ t_s;
    w1_s   = prev_s[63:32]  ^ w0_s;
    w2_s   = prev_s[95:64]  ^ w1_s;
    w3_s   = prev_s[127:96] ^ w2_s;
    next_s = {w3_s, w2_s, w1_s, w0_s};
  end

  // Round-key store. A load captures the cipher key and can wipe stale keys.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= AES128_NR; i++) rk_r[i] <= 128'h0;
    end else if (load) begin
      rk_r[0] <= key;
      if (clear) begin
        for (int i = 1; i <= AES128_NR; i++) rk_r[i] <= 128'h0;
      end
    end else if (step && idx_ok_s) begin
      rk_r[idx] <= next_s;
    end
  end

  // Indexed read port. An out-of-range index reads as zero.
  always_comb begin
    if (rd_idx <= 4'd10) begin
      rd_key = rk_r[rd_idx];
    end else begin
      rd_key = 128'h0;
    end
  end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher. It runs one round per clock and expands
// its own key. Each block takes 1 accept cycle, 10 round cycles and 1
// output cycle.
// Optional build macro AES_INV_CIPHER_ZEROIZE_EN enables zeroization:
//   - out_data reads 0 while no result is valid.
//   - The state register is wiped after the output handshake.
//   - Stale round keys are wiped when a new key is loaded in READY.
module aes_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int NR = AES128_NR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  if (NR != AES128_NR) begin : g_nr_check
    $error("aes_inv_cipher_iter: only NR=10 (AES-128) is supported");
  end

  aes_inv_state_e state_r, state_s;
  logic [3:0]     cnt_r;
  aes_block_t     st_r;
  logic           out_valid_r;
  logic           busy_r;

  logic           key_ready_s, in_ready_s;
  logic           key_fire_s, in_fire_s;
  logic           ke_clear_s;
  logic [3:0]     rd_idx_s;
  aes_block_t     rk_rd_s;
  aes_block_t     dec_s, ark_s, round_s;

  // Handshake qualifiers. A key offer in READY masks the ciphertext accept.
  always_comb begin
    key_ready_s = (state_r == IDLE) || (state_r == READY);
    in_ready_s  = (state_r == READY) && !key_valid;
    key_fire_s  = key_valid && key_ready_s;
    in_fire_s   = in_valid && in_ready_s;
    if (state_r == ROUND) begin
      rd_idx_s = cnt_r;
    end else begin
      rd_idx_s = 4'd10;
    end
  end

`ifdef AES_INV_CIPHER_ZEROIZE_EN
  assign ke_clear_s = key_fire_s && (state_r == READY);
`else
  assign ke_clear_s = 1'b0;
`endif

  aes_key_expand_128 u_key_expand (
    .clk    (clk),
    .rst    (rst),
    .load   (key_fire_s),
    .clear  (ke_clear_s),
    .step   (state_r == KEXP),
    .idx    (cnt_r),
    .key    (key),
    .rd_idx (rd_idx_s),
    .rd_key (rk_rd_s)
  );

  // One inverse round. MixColumns is skipped on the final round (r=0).
  always_comb begin
    dec_s = inv_sub_bytes(inv_shift_rows(st_r));
    ark_s = add_round_key(dec_s, rk_rd_s);
    if (cnt_r == 4'd0) begin
      round_s = ark_s;
    end else begin
      round_s = inv_mix_columns(ark_s);
    end
  end

  // Next-state logic for the control FSM.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (key_fire_s) state_s = KEXP;
        else            state_s = IDLE;
      end
      KEXP: begin
        if (cnt_r == 4'd10) state_s = READY;
        else                state_s = KEXP;
      end
      READY: begin
        if (key_fire_s)     state_s = KEXP;
        else if (in_fire_s) state_s = ROUND;
        else                state_s = READY;
      end
      ROUND: begin
        if (cnt_r == 4'd0) state_s = DONE;
        else               state_s = ROUND;
      end
      DONE: begin
        if (out_ready) state_s = READY;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register, registered status outputs, and the round counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      out_valid_r <= (state_s == DONE);
      busy_r      <= (state_s == KEXP) || (state_s == ROUND);
      case (state_r)
        IDLE: begin
          if (key_fire_s) cnt_r <= 4'd1;
        end
        KEXP: begin
          if (cnt_r == 4'd10) cnt_r <= 4'd0;
          else                cnt_r <= cnt_r + 4'd1;
        end
        READY: begin
          if (key_fire_s)     cnt_r <= 4'd1;
          else if (in_fire_s) cnt_r <= 4'd9;
        end
        ROUND: begin
          if (cnt_r != 4'd0) cnt_r <= cnt_r - 4'd1;
        end
        default: cnt_r <= 4'd0;
      endcase
    end
  end

  // Cipher state register: initial whitening on accept, then one round per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_r <= 128'h0;
    end else begin
      case (state_r)
        READY: begin
          if (!key_fire_s && in_fire_s) st_r <= add_round_key(in_data, rk_rd_s);
        end
        ROUND: begin
          st_r <= round_s;
        end
`ifdef AES_INV_CIPHER_ZEROIZE_EN
        DONE: begin
          if (out_ready) st_r <= 128'h0;
        end
`endif
        default: st_r <= st_r;
      endcase
    end
  end

  assign key_ready = key_ready_s;
  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;

`ifdef AES_INV_CIPHER_ZEROIZE_EN
  assign out_data = out_valid_r ? st_r : 128'h0;
`else
  assign out_data = st_r;
`endif

endmodule
